// File: rtl/param_sync_ram_pkg.sv
// Shared types and helpers for param_sync_ram: FSM state encoding and even-parity generation.
package param_sync_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Widest word the parity helper accepts; DATA_W must not exceed this.
  localparam int unsigned PAR_MAX_W = 64;

  // Even parity over the low w bits of d: returns the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d, input int unsigned w);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
      if (i < w) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/param_sync_ram_core.sv
// Storage array for param_sync_ram: one synchronous write port and one registered read port sharing an address.
module param_sync_ram_core #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [WORD_W-1:0] wword,
  input  logic              re,
  output logic [WORD_W-1:0] rword
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rword_q;

  // Array contents are deliberately not reset; the owner zero-fills them.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wword;
  end

  // Read register holds its value between reads and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rword_q <= '0;
    end else if (re) begin
      rword_q <= mem[addr];
    end
  end

  assign rword = rword_q;

endmodule

// File: rtl/param_sync_ram.sv
// Single-port RAM with req/ready handshake, registered read data + rvalid, and a zero-fill engine after reset/clr.
// Optional feature macro: RAM_PARITY_EN (stores an even-parity bit per word and reports par_err on reads).
module param_sync_ram
  import param_sync_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              init_done,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              par_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              ready_q, init_done_q, init_done_d, rvalid_q;
  logic              fill_last_c;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wword, req_wword, mem_rword;

`ifdef RAM_PARITY_EN
  assign req_wword = {even_parity(PAR_MAX_W'(wdata), DATA_W), wdata};
`else
  assign req_wword = wdata;
`endif

  assign fill_last_c = (fill_cnt_q == ADDR_W'(DEPTH - 1));

  // Next-state, fill sequencing and storage-port steering.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = addr;
    mem_wword   = req_wword;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_addr   = fill_cnt_q;
        mem_wword  = '0;
        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        if (fill_last_c) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        // clr takes priority and drops any request presented with it.
        if (clr) begin
          state_d    = ST_INIT;
          fill_cnt_d = '0;
        end else if (req && ready_q) begin
          mem_we = we;
          mem_re = !we;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      fill_cnt_q  <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      ready_q     <= (state_d == ST_IDLE);
      init_done_q <= init_done_d;
      rvalid_q    <= mem_re;
    end
  end

  param_sync_ram_core #(
    .WORD_W (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (mem_addr),
    .we    (mem_we),
    .wword (mem_wword),
    .re    (mem_re),
    .rword (mem_rword)
  );

  assign ready     = ready_q;
  assign init_done = init_done_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rword[DATA_W-1:0];

`ifdef RAM_PARITY_EN
  // Check is made on the registered read word, so it lines up with rdata and is gated by rvalid.
  assign par_err = rvalid_q &&
                   (even_parity(PAR_MAX_W'(mem_rword[DATA_W-1:0]), DATA_W) != mem_rword[DATA_W]);
`else
  assign par_err = 1'b0;
`endif

endmodule
